// File: rtl/bascomp_io_pkg.sv
// Shared constants and helpers for the basic-computer I/O blocks.
package bascomp_io_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 4;

    function automatic int addr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/input_buffer_if.sv
// Keyboard/CPU side of the input buffer: character in, head entry and status flags out.
interface input_buffer_if
    import bascomp_io_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int CW = addr_w(DEPTH) + 1;

    logic [WIDTH-1:0] keyboard_input;
    logic             input_arrived_flag;
    logic             inp_read;
    logic             ovf_clear;
    logic [WIDTH-1:0] input_data;
    logic             fgi;
    logic [CW-1:0]    count;
    logic             overflow;

    modport master (
        output keyboard_input, input_arrived_flag, inp_read, ovf_clear,
        input  input_data, fgi, count, overflow
    );

    modport slave (
        input  keyboard_input, input_arrived_flag, inp_read, ovf_clear,
        output input_data, fgi, count, overflow
    );

endinterface

// File: rtl/input_buffer_strobe_edge_detect.sv
// Rising-edge detector for the keyboard strobe; INPUT_BUFFER_SYNC_EN adds a 2-flop
// synchroniser in front so the strobe may be asynchronous to clk.
module strobe_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic flag_i,
    output logic push_evt_o
);

    logic flag_s;
    logic flag_q;
    logic armed_q;

`ifdef INPUT_BUFFER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], flag_i};
    end

    assign flag_s = sync_q[1];
`else
    assign flag_s = flag_i;
`endif

    // armed_q blocks the first edge after reset so a strobe already high then is not a push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            flag_q  <= flag_s;
            armed_q <= 1'b1;
        end
    end

    assign push_evt_o = flag_s & ~flag_q & armed_q;

endmodule

// File: rtl/input_buffer.sv
// DEPTH-entry keyboard character FIFO with FGI-style available flag and sticky overflow.
// Build option: INPUT_BUFFER_SYNC_EN (synchronise the keyboard strobe, see strobe_edge_detect).
module input_buffer
    import bascomp_io_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input_buffer_if.slave  bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             ovf_q,    ovf_d;

    logic push_evt;
    logic empty, full;
    logic push_ok, pop_ok, drop;

    strobe_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .flag_i     (bus.input_arrived_flag),
        .push_evt_o (push_evt)
    );

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign pop_ok  = bus.inp_read & ~empty;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push_ok = push_evt & (~full | pop_ok);
    assign drop    = push_evt & full & ~pop_ok;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        ovf_d = ovf_q;
        if (drop)               ovf_d = 1'b1;
        else if (bus.ovf_clear) ovf_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.keyboard_input;
    end

    assign bus.input_data = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.fgi        = ~empty;
    assign bus.count      = count_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_input_buffer.sv
// Self-checking bench for input_buffer: vector table, scoreboarded wrap sequence,
// asynchronous mid-run reset, and the synchronised-strobe latency when enabled.
module tb_input_buffer;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    input_buffer_if #(.WIDTH(8), .DEPTH(4)) bus ();

    input_buffer #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       strb;
        logic [7:0] din;
        logic       rd;
        logic       clr;
        logic [2:0] cnt;
        logic       fgi;
        logic       ovf;
        logic [7:0] dout;
    } vec_t;

    vec_t      vecs[$];
    logic [7:0] exp_q[$];

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive_step(input logic s, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        bus.input_arrived_flag = s;
        bus.keyboard_input     = d;
        bus.inp_read           = r;
        bus.ovf_clear          = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic [7:0] d, input logic r, input logic c,
                       input logic [2:0] n, input logic f, input logic o, input logic [7:0] q);
        vecs.push_back('{s, d, r, c, n, f, o, q});
    endtask

    task automatic check_outputs(input string nm, input int idx,
                                 input logic [2:0] n, input logic f, input logic o, input logic [7:0] q);
        check({nm, ".count"},    idx, 32'(bus.count),      32'(n));
        check({nm, ".fgi"},      idx, 32'(bus.fgi),        32'(f));
        check({nm, ".overflow"}, idx, 32'(bus.overflow),   32'(o));
        check({nm, ".data"},     idx, 32'(bus.input_data), 32'(q));
    endtask

    initial begin
        reset                  = 1'b1;
        bus.input_arrived_flag = 1'b1;
        bus.keyboard_input     = 8'h00;
        bus.inp_read           = 1'b0;
        bus.ovf_clear          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 3'd0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;

`ifdef INPUT_BUFFER_SYNC_EN
        begin
            int n;
            n = 0;
            bus.input_arrived_flag = 1'b0;
            bus.keyboard_input     = 8'h5A;
            repeat (4) @(posedge clk);
            @(negedge clk);
            #2;
            bus.input_arrived_flag = 1'b1;
            while (n < 10 && !bus.fgi) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("sync_latency", 0, 32'(n), 32'd3);
            check("sync_data", 0, 32'(bus.input_data), 32'h5A);
        end
`else
        // Strobe high through reset release: no push until it falls and rises again.
        add(1, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
        // single character in and out
        add(1, 8'h41, 0, 0, 1, 1, 0, 8'h41);
        add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        // fill, overflow on fifth (clear in same cycle loses), drain in order, clear
        add(1, 8'h01, 0, 0, 1, 1, 0, 8'h01);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h01);
        add(1, 8'h02, 0, 0, 2, 1, 0, 8'h01);
        add(0, 8'h00, 0, 0, 2, 1, 0, 8'h01);
        add(1, 8'h03, 0, 0, 3, 1, 0, 8'h01);
        add(0, 8'h00, 0, 0, 3, 1, 0, 8'h01);
        add(1, 8'h04, 0, 0, 4, 1, 0, 8'h01);
        add(0, 8'h00, 0, 0, 4, 1, 0, 8'h01);
        add(1, 8'h05, 0, 1, 4, 1, 1, 8'h01);
        add(0, 8'h00, 1, 0, 3, 1, 1, 8'h02);
        add(0, 8'h00, 1, 0, 2, 1, 1, 8'h03);
        add(0, 8'h00, 1, 0, 1, 1, 1, 8'h04);
        add(0, 8'h00, 1, 0, 0, 0, 1, 8'h00);
        add(0, 8'h00, 0, 1, 0, 0, 0, 8'h00);
        // push and pop together while full
        add(1, 8'h11, 0, 0, 1, 1, 0, 8'h11);
        add(0, 8'h00, 0, 0, 1, 1, 0, 8'h11);
        add(1, 8'h22, 0, 0, 2, 1, 0, 8'h11);
        add(0, 8'h00, 0, 0, 2, 1, 0, 8'h11);
        add(1, 8'h33, 0, 0, 3, 1, 0, 8'h11);
        add(0, 8'h00, 0, 0, 3, 1, 0, 8'h11);
        add(1, 8'h44, 0, 0, 4, 1, 0, 8'h11);
        add(0, 8'h00, 0, 0, 4, 1, 0, 8'h11);
        add(1, 8'hAA, 1, 0, 4, 1, 0, 8'h22);
        add(0, 8'h00, 1, 0, 3, 1, 0, 8'h33);
        add(0, 8'h00, 1, 0, 2, 1, 0, 8'h44);
        add(0, 8'h00, 1, 0, 1, 1, 0, 8'hAA);
        add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        // held strobe pushes once; read when empty is ignored
        for (int i = 0; i < 10; i++) add(1, 8'h55, 0, 0, 1, 1, 0, 8'h55);
        add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_step(vecs[i].strb, vecs[i].din, vecs[i].rd, vecs[i].clr);
            check_outputs("vec", i, vecs[i].cnt, vecs[i].fgi, vecs[i].ovf, vecs[i].dout);
        end

        // Interleaved pushes and reads across several pointer wraps, scoreboarded.
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            logic       r;
            d = 8'(8'h60 + i * 7);
            r = (i % 3) != 0;
            drive_step(1'b1, d, 1'b0, 1'b0);
            if (exp_q.size() < 4) exp_q.push_back(d);
            check("sb.count", i, 32'(bus.count), 32'(exp_q.size()));
            check("sb.head", i, 32'(bus.input_data), 32'(exp_q.size() > 0 ? exp_q[0] : 8'h00));
            drive_step(1'b0, 8'h00, r, 1'b0);
            if (r && exp_q.size() > 0) void'(exp_q.pop_front());
            check("sb.head_after_rd", i, 32'(bus.input_data), 32'(exp_q.size() > 0 ? exp_q[0] : 8'h00));
        end
        check("sb.overflow", 0, 32'(bus.overflow), 32'd0);

        // Asynchronous reset with entries stored clears outputs before any clock edge.
        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 0, 3'd0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        drive_step(1'b0, 8'h00, 1'b0, 1'b0);
        check_outputs("post_reset", 0, 3'd0, 1'b0, 1'b0, 8'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
